// File: rtl/hdmi_frame_writer_pkg.sv
// hdmi_frame_writer_pkg: shared FSM state type, pixel format constants and DDR-derived defaults.
// Pixel format: HDMI_IN_RGB565_EN defined packs 16-bit RGB565 pixels, otherwise 24-bit RGB888.
package hdmi_frame_writer_pkg;
  localparam int MEM_DQ_WIDTH = 32;
  localparam int CTRL_ADDR_WIDTH = 28;
  localparam int DEF_DATA_W = MEM_DQ_WIDTH * 8;
  localparam int DEF_ADDR_W = CTRL_ADDR_WIDTH;
  localparam int DEF_FRAME_NUM = 3;
  localparam int FRAME_IDX_W = $clog2(DEF_FRAME_NUM);
`ifdef HDMI_IN_RGB565_EN
  localparam int PIX_W = 16;
`else
  localparam int PIX_W = 24;
`endif
  localparam int DEF_PPW = DEF_DATA_W / PIX_W;
  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT} wr_state_e;
  function automatic logic [PIX_W-1:0] pack_pix(input logic [23:0] p);
`ifdef HDMI_IN_RGB565_EN
    return {p[23:19], p[15:10], p[7:3]};
`else
    return p;
`endif
  endfunction
endpackage

// File: rtl/pix_word_fifo.sv
// pix_word_fifo: synchronous word FIFO with occupancy count and registered read.
// Ports: clk/rst (sync, active-high); wr_en_i/wr_data_i push; rd_en_i pops and loads rd_data_o
// on the next edge; count_o occupancy; full_o at DEPTH. A push while full is accepted only
// when a pop happens in the same cycle.
module pix_word_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [DATA_W-1:0] rd_data_q;
  logic do_wr, do_rd;
  assign do_rd = rd_en_i && count_q != '0;
  assign do_wr = wr_en_i && (count_q != CW'(DEPTH) || do_rd);
  assign rd_data_o = rd_data_q;
  assign count_o = count_q;
  assign full_o = count_q == CW'(DEPTH);
  always_ff @(posedge clk) if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_data_q <= mem[rd_ptr_q];
      end
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/hdmi_frame_writer.sv
// hdmi_frame_writer: packs a pixel stream into DDR words and writes them in bursts across FRAME_NUM buffers.
// Ports: ddr_clk/rst (sync, active-high); ini_done gates pixel intake and bursts;
// pix_* pixel stream with sof/eol/eof markers; wr_req/awlen/ddr_waddr request a burst,
// wr_busy/wr_data_req/wr_done are the controller handshake; ddr_wdata beat data;
// frame_done/frame_idx report a completed frame; overflow flags a dropped word.
// Macro: HDMI_IN_RGB565_EN selects 16-bit pixel packing.
module hdmi_frame_writer
  import hdmi_frame_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BURST_LEN = 8,
  parameter int ADDR_INC = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int FRAME_NUM = DEF_FRAME_NUM,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'('h80_0000)
) (
  input  logic                         ddr_clk,
  input  logic                         rst,
  input  logic                         ini_done,
  input  logic                         pix_valid,
  input  logic [23:0]                  pix_data,
  input  logic                         pix_sof,
  input  logic                         pix_eol,
  input  logic                         pix_eof,
  input  logic                         wr_busy,
  input  logic                         wr_data_req,
  input  logic                         wr_done,
  output logic                         wr_req,
  output logic [3:0]                   awlen,
  output logic [ADDR_W-1:0]            ddr_waddr,
  output logic [DATA_W-1:0]            ddr_wdata,
  output logic                         frame_done,
  output logic [$clog2(FRAME_NUM)-1:0] frame_idx,
  output logic                         overflow
);
  localparam int PPW = DATA_W / PIX_W;
  localparam int SW = $clog2(PPW);
  localparam int IW = $clog2(FRAME_NUM);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  wr_state_e state_q, state_d;
  logic [SW-1:0] slot_q, slot;
  logic [DATA_W-1:0] word_q, word_d, pword_q;
  logic push_q, peof_q, take, complete;
  logic pop, last_beat, drop, done_c, apply_sof, go_req, fifo_full;
  logic flush_q, sof_pend_q, first_q, overflow_q;
  logic [IW-1:0] buf_q, next_buf, frame_idx_q;
  logic [3:0] awlen_q, beat_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [CW-1:0] count, burst_n;
  pix_word_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(ddr_clk),
    .rst(rst),
    .wr_en_i(push_q),
    .wr_data_i(pword_q),
    .rd_en_i(pop),
    .rd_data_o(ddr_wdata),
    .count_o(count),
    .full_o(fifo_full)
  );
  // sof restarts packing at slot 0 so a partial word from the old frame is dropped
  always_comb begin
    take = ini_done && pix_valid;
    slot = pix_sof ? '0 : slot_q;
    word_d = pix_sof ? '0 : word_q;
    for (int k = 0; k < PPW; k++) if (slot == SW'(k)) word_d[k*PIX_W +: PIX_W] = pack_pix(pix_data);
    complete = slot == SW'(PPW - 1) || pix_eol || pix_eof;
  end
  // A pending flush finishes the old frame before a pending sof moves the pointer
  always_comb begin
    pop = state_q == DATA && wr_data_req;
    last_beat = pop && beat_q == awlen_q;
    drop = push_q && fifo_full && !pop;
    done_c = state_q == IDLE && flush_q && count == '0;
    apply_sof = state_q == IDLE && sof_pend_q && !flush_q;
    go_req = state_q == IDLE && ini_done && !apply_sof && (count >= CW'(BURST_LEN) || (flush_q && count != '0));
    burst_n = count >= CW'(BURST_LEN) ? CW'(BURST_LEN) : count;
    next_buf = (first_q || buf_q == IW'(FRAME_NUM - 1)) ? '0 : buf_q + 1'b1;
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = go_req ? REQ : IDLE;
      REQ: state_d = wr_busy ? DATA : REQ;
      DATA: state_d = last_beat ? WAIT : DATA;
      WAIT: state_d = wr_done ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ddr_clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q <= '0;
      word_q <= '0;
      pword_q <= '0;
      push_q <= 1'b0;
      peof_q <= 1'b0;
      flush_q <= 1'b0;
      sof_pend_q <= 1'b0;
      first_q <= 1'b1;
      overflow_q <= 1'b0;
      buf_q <= '0;
      frame_idx_q <= IW'(FRAME_NUM - 1);
      awlen_q <= '0;
      beat_q <= '0;
      waddr_q <= FRAME_BASE;
    end else begin
      state_q <= state_d;
      if (take) begin
        slot_q <= complete ? '0 : slot + 1'b1;
        word_q <= complete ? '0 : word_d;
      end
      push_q <= take && complete;
      pword_q <= word_d;
      peof_q <= take && pix_eof;
      flush_q <= (push_q && peof_q) || (flush_q && !done_c);
      sof_pend_q <= (take && pix_sof) || (sof_pend_q && !apply_sof);
      overflow_q <= !(take && pix_sof) && (overflow_q || drop);
      if (apply_sof) begin
        buf_q <= next_buf;
        first_q <= 1'b0;
      end
      if (done_c && !overflow_q) frame_idx_q <= buf_q;
      if (go_req) awlen_q <= 4'(burst_n - 1'b1);
      beat_q <= state_q == DATA ? beat_q + 4'(pop) : '0;
      waddr_q <= apply_sof ? FRAME_BASE + ADDR_W'(next_buf) * FRAME_STRIDE :
                 (state_q == WAIT && wr_done) ? waddr_q + ADDR_W'(ADDR_INC * (int'(awlen_q) + 1) / BURST_LEN) : waddr_q;
    end
  end
  // A frame that lost a word still drains but is never reported
  assign frame_done = done_c && !overflow_q;
  assign frame_idx = frame_done ? buf_q : frame_idx_q;
  assign wr_req = state_q == REQ;
  assign awlen = awlen_q;
  assign ddr_waddr = waddr_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_hdmi_frame_writer.sv
// tb_hdmi_frame_writer: directed bench with a burst-responding controller model and a pixel packing model.
module tb_hdmi_frame_writer;
  localparam int DATA_W = 256;
`ifdef HDMI_IN_RGB565_EN
  localparam int PW = 16;
`else
  localparam int PW = 24;
`endif
  localparam int PPW = DATA_W / PW;
  localparam logic [27:0] STRIDE = 28'h080_0000;
  logic ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;
  logic rst, ini_done, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [23:0] pix_data;
  logic wr_busy, wr_data_req, wr_done, wr_req, frame_done, overflow;
  logic [3:0] awlen;
  logic [27:0] ddr_waddr;
  logic [255:0] ddr_wdata;
  logic [1:0] frame_idx;
  hdmi_frame_writer dut (
    .ddr_clk(ddr_clk), .rst(rst), .ini_done(ini_done), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .wr_busy(wr_busy), .wr_data_req(wr_data_req),
    .wr_done(wr_done), .wr_req(wr_req), .awlen(awlen), .ddr_waddr(ddr_waddr), .ddr_wdata(ddr_wdata),
    .frame_done(frame_done), .frame_idx(frame_idx), .overflow(overflow)
  );
  int checks = 0, fails = 0, done_n = 0;
  bit ctrl_en;
  logic [1:0] last_idx = 2'b11;
  logic [255:0] got_q[$], exp_q[$];
  logic [27:0] baddr_q[$];
  logic [3:0] blen_q[$];
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [PW-1:0] enc(input logic [23:0] p);
`ifdef HDMI_IN_RGB565_EN
    return {p[23:19], p[15:10], p[7:3]};
`else
    return p;
`endif
  endfunction
  // Controller: grants a request, pulls awlen+1 beats back to back, then signals done
  initial begin
    int ph, left;
    bit cap;
    ph = 0; left = 0; cap = 0;
    wr_busy = 0; wr_data_req = 0; wr_done = 0;
    forever begin
      @(posedge ddr_clk); #2;
      if (cap) got_q.push_back(ddr_wdata);
      if (frame_done) begin
        done_n++;
        last_idx = frame_idx;
      end
      if (rst) begin
        ph = 0; wr_busy = 0; wr_data_req = 0; wr_done = 0;
      end else case (ph)
        0: if (ctrl_en && wr_req) begin
          baddr_q.push_back(ddr_waddr);
          blen_q.push_back(awlen);
          left = int'(awlen) + 1;
          wr_busy = 1;
          ph = 1;
        end
        1: begin wr_busy = 0; wr_data_req = 1; left--; ph = 2; end
        2: if (left == 0) begin wr_data_req = 0; wr_done = 1; ph = 3; end else left--;
        default: begin wr_done = 0; ph = 0; end
      endcase
      cap = wr_data_req;
    end
  end
  task automatic send(input int n, input bit sof, input bit eof, input logic [7:0] tag, input bit model);
    logic [255:0] w;
    int s;
    w = '0; s = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge ddr_clk); #1;
      pix_valid = 1;
      pix_data = (tag == 8'hFF) ? 24'hFFFFFF : {tag, 16'(i)};
      pix_sof = sof && i == 0;
      pix_eol = i == n - 1;
      pix_eof = eof && i == n - 1;
      w[s*PW +: PW] = enc(pix_data);
      s++;
      if (s == PPW || i == n - 1) begin
        if (model) exp_q.push_back(w);
        w = '0; s = 0;
      end
    end
    @(posedge ddr_clk); #1;
    pix_valid = 0; pix_sof = 0; pix_eol = 0; pix_eof = 0;
  endtask
  task automatic wait_done(input int n, input int budget, input string tag);
    int c = 0;
    while (done_n < n && c < budget) begin @(posedge ddr_clk); c++; end
    #3;
    check({tag, "_done_count"}, done_n, n);
  endtask
  task automatic cmp_frame(input string tag, input int nb, input logic [27:0] base, input logic [3:0] last_len, input logic [1:0] idx);
    check({tag, "_bursts"}, baddr_q.size(), nb);
    for (int i = 0; i < nb && i < baddr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), baddr_q[i], base + 28'(64 * i));
      check($sformatf("%s_len%0d", tag, i), blen_q[i], (i == nb - 1) ? last_len : 4'd7);
    end
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_idx"}, last_idx, idx);
    got_q.delete(); exp_q.delete(); baddr_q.delete(); blen_q.delete();
  endtask
  initial begin
    int c;
    rst = 1; ini_done = 0; ctrl_en = 1;
    pix_valid = 0; pix_data = '0; pix_sof = 0; pix_eol = 0; pix_eof = 0;
    repeat (3) @(posedge ddr_clk);
    #1 rst = 0;
    check("rst_wr_req", wr_req, 0);
    check("rst_awlen", awlen, 0);
    check("rst_waddr", ddr_waddr, 0);
    check("rst_wdata", ddr_wdata, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_idx", frame_idx, 2);
    check("rst_overflow", overflow, 0);
    send(30, 1, 1, 8'h11, 0);
    repeat (40) @(posedge ddr_clk);
    #1;
    check("noini_bursts", baddr_q.size(), 0);
    check("noini_done", done_n, 0);
    ini_done = 1;
    send(25, 1, 1, 8'h20, 1);
    wait_done(1, 300, "f0");
    cmp_frame("f0", 1, 28'h0, 4'd2, 2'd0);
    send(1920, 1, 1, 8'h31, 1);
    wait_done(2, 2000, "f1");
    cmp_frame("f1", 24, STRIDE, 4'd7, 2'd1);
    send(20, 1, 1, 8'h42, 1);
    wait_done(3, 300, "f2");
    cmp_frame("f2", 1, 2 * STRIDE, 4'(((20 + PPW - 1) / PPW) - 1), 2'd2);
    send(20, 1, 1, 8'h53, 1);
    wait_done(4, 300, "f3");
    cmp_frame("f3", 1, 28'h0, 4'(((20 + PPW - 1) / PPW) - 1), 2'd0);
    ctrl_en = 0;
    send(800, 1, 1, 8'h64, 0);
    check("ovf_set", overflow, 1);
    ctrl_en = 1;
    repeat (300) @(posedge ddr_clk);
    #1;
    check("ovf_no_done", done_n, 4);
    check("ovf_drain_bursts", blen_q.size(), 8);
    check("ovf_sticky", overflow, 1);
    got_q.delete(); baddr_q.delete(); blen_q.delete();
    send(20, 1, 1, 8'h75, 1);
    check("ovf_clear", overflow, 0);
    wait_done(5, 300, "f5");
    cmp_frame("f5", 1, 2 * STRIDE, 4'(((20 + PPW - 1) / PPW) - 1), 2'd2);
    ctrl_en = 0;
    send(200, 1, 0, 8'h86, 0);
    ctrl_en = 1;
    c = 0;
    while (got_q.size() < 10 && c < 300) begin @(posedge ddr_clk); #1; c++; end
    check("mid_beats_reached", got_q.size() >= 10, 1);
    check("mid_waddr", ddr_waddr, 28'd64);
    rst = 1;
    @(posedge ddr_clk);
    #1 rst = 0;
    check("mid_rst_wr_req", wr_req, 0);
    check("mid_rst_waddr", ddr_waddr, 0);
    check("mid_rst_wdata", ddr_wdata, 0);
    check("mid_rst_frame_idx", frame_idx, 2);
    got_q.delete(); baddr_q.delete(); blen_q.delete();
    repeat (30) @(posedge ddr_clk);
    #1;
    check("mid_rst_fifo_empty", baddr_q.size(), 0);
    send(25, 1, 1, 8'h97, 1);
    wait_done(6, 300, "f7");
    cmp_frame("f7", 1, 28'h0, 4'd2, 2'd0);
    send(32, 1, 1, 8'hFF, 1);
    wait_done(7, 300, "f8");
    cmp_frame("f8", 1, STRIDE, 4'(((32 + PPW - 1) / PPW) - 1), 2'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
